// File: rtl/prog_mem.sv
// Clocked program memory: byte-serial boot loader fills words MSB-first,
// then a registered read port serves instruction fetch with one cycle of latency.
//
// state  | meaning
// IDLE   | after reset; waiting for load_start, reads ignored
// LOAD   | assembling bytes into words and writing them (busy=1)
// RUN    | serving reads; load_start begins a fresh load
module prog_mem #(
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 16,
    parameter int                DEPTH        = 256,
    parameter logic [DATA_W-1:0] DEFAULT_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_end,
    output logic              load_done,
    output logic              busy,
    output logic [ADDR_W:0]   words_loaded,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(BYTES) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ADDR_W:0]  LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   byte_cnt;
    logic [DATA_W-1:0]  asm_word;
    logic [DATA_W+7:0]  shift_word;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               word_done;
    logic               mem_full;
    logic               rd_accept;
    logic               rd_hit;

    assign shift_word = {asm_word, load_byte};
    assign word_done  = (state == S_LOAD) && load_valid && (byte_cnt == LAST_BYTE);
    assign mem_full   = word_done && (words_loaded == LAST_WORD);
    assign rd_accept  = (state == S_RUN) && rd_en;
    // words_loaded never exceeds DEPTH, so a hit is always a legal index
    assign rd_hit     = ({1'b0, rd_addr} < words_loaded);
    assign busy       = (state == S_LOAD);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load_start) state_nxt = S_LOAD;
            S_LOAD:  if (mem_full || load_end) state_nxt = S_RUN;
            S_RUN:   if (load_start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (word_done)
            mem[words_loaded[IDX_W-1:0]] <= shift_word[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            asm_word     <= '0;
            words_loaded <= '0;
            rd_data      <= DEFAULT_WORD;
            rd_valid     <= 1'b0;
            load_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_valid  <= rd_accept;
            load_done <= (state == S_LOAD) && (state_nxt == S_RUN);
            if (rd_accept)
                rd_data <= rd_hit ? mem[rd_addr[IDX_W-1:0]] : DEFAULT_WORD;
            case (state)
                S_IDLE: begin
                    byte_cnt     <= '0;
                    words_loaded <= '0;
                end
                S_LOAD: begin
                    if (load_valid) begin
                        asm_word <= shift_word[DATA_W-1:0];
                        byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
                        if (word_done)
                            words_loaded <= words_loaded + 1'b1;
                    end
                    // a partial word is dropped when the load finishes
                    if (state_nxt == S_RUN)
                        byte_cnt <= '0;
                end
                S_RUN: begin
                    if (load_start) begin
                        byte_cnt     <= '0;
                        words_loaded <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem (DEPTH=4, DEFAULT_WORD=DEAD) with a read scoreboard
// and cycle-by-cycle checks of rd_valid/rd_data.
module tb_prog_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, load_valid, load_end;
    logic [7:0]  load_byte;
    logic        load_done, busy;
    logic [8:0]  words_loaded;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          done_exp = 0;
    logic        pend = 1'b0;
    logic [15:0] hold = 16'hDEAD;
    logic [15:0] exp_q [$];

    prog_mem #(
        .ADDR_W(8), .DATA_W(16), .DEPTH(4), .DEFAULT_WORD(16'hDEAD)
    ) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_end(load_end), .load_done(load_done), .busy(busy),
        .words_loaded(words_loaded),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        load_end   = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = 8'h00;
    endtask

    // one clock: check read outputs produced by the last edge, then release inputs
    task automatic tick();
        @(negedge clk);
        if (load_done === 1'b1) done_cnt++;
        check("rd_valid", {31'b0, rd_valid}, {31'b0, pend});
        if (pend) begin
            if (exp_q.size() > 0) hold = exp_q.pop_front();
        end
        check("rd_data", {16'b0, rd_data}, {16'b0, hold});
        pend = 1'b0;
        clear_inputs();
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        pend = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_end   = last;
        tick();
    endtask

    logic [7:0]  t2_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [7:0]  rd_addrs [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd200};
    logic [15:0] t2_words [6] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'hDEAD, 16'hDEAD};
    logic [15:0] t3_words [4] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state; reads ignored in IDLE
        tick();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_words", {23'b0, words_loaded}, 32'd0);
        check("reset_done", {31'b0, load_done}, 32'd0);
        rd_en = 1'b1; rd_addr = 8'd0;
        tick();

        // eight bytes fill all four words; reads in LOAD are ignored
        load_start = 1'b1;
        tick();
        check("load_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin rd_en = 1'b1; rd_addr = 8'd0; end
            send(t2_bytes[i], 1'b0);
        end
        done_exp++;
        check("t2_busy", {31'b0, busy}, 32'd0);
        check("t2_words", {23'b0, words_loaded}, 32'd4);
        load_end = 1'b1;
        tick();
        check("t2_done", done_cnt, done_exp);
        for (int i = 0; i < 6; i++) begin
            rd(rd_addrs[i], t2_words[i]);
            tick();
        end

        // full memory ends the load; trailing bytes ignored
        load_start = 1'b1;
        tick();
        check("t3_words_clr", {23'b0, words_loaded}, 32'd0);
        check("t3_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            send(8'(i + 1), 1'b0);
            if (i == 7) check("t3_auto_run", {31'b0, busy}, 32'd0);
        end
        done_exp++;
        check("t3_done", done_cnt, done_exp);
        check("t3_words", {23'b0, words_loaded}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            rd(8'(i), t3_words[i]);
            tick();
        end

        // load_end with a partial word pending
        load_start = 1'b1;
        tick();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        done_exp++;
        check("t4_words", {23'b0, words_loaded}, 32'd1);
        check("t4_done", done_cnt, done_exp);
        rd(8'd0, 16'hAABB); tick();
        rd(8'd1, 16'hDEAD); tick();

        // load_end on the byte that completes a word
        load_start = 1'b1;
        tick();
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        done_exp++;
        check("t4b_words", {23'b0, words_loaded}, 32'd1);
        check("t4b_done", done_cnt, done_exp);
        rd(8'd0, 16'h1122); tick();

        // read and load_start together
        rd(8'd0, 16'h1122);
        load_start = 1'b1;
        tick();
        check("t5_busy", {31'b0, busy}, 32'd1);
        check("t5_words", {23'b0, words_loaded}, 32'd0);
        load_end = 1'b1;
        tick();
        done_exp++;
        check("t5_done", done_cnt, done_exp);
        rd(8'd0, 16'hDEAD); tick();

        // reset in the middle of a load
        load_start = 1'b1;
        tick();
        send(8'h5A, 1'b0);
        send(8'h5B, 1'b0);
        send(8'h5C, 1'b0);
        rst = 1'b1;
        hold = 16'hDEAD;
        tick();
        rst = 1'b0;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_words", {23'b0, words_loaded}, 32'd0);
        check("t6_done", done_cnt, done_exp);
        rd_en = 1'b1; rd_addr = 8'd0;
        tick();
        load_start = 1'b1;
        tick();
        load_end = 1'b1;
        tick();
        done_exp++;
        check("t6_reload_done", done_cnt, done_exp);
        rd(8'd0, 16'hDEAD); tick();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
